// File: rtl/bar_foo_handshake_rx.sv
// Three-lane round-robin valid/ready receiver feeding a lane-tagged FIFO,
// with sticky per-lane flags for producers that retract or alter a stalled beat.
module bar_foo_handshake_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       ASYNCRESET,
  input  logic                       handshake_arr_0_valid,
  output logic                       handshake_arr_0_ready,
  input  logic [WIDTH-1:0]           handshake_arr_0_data,
  input  logic                       handshake_arr_1_valid,
  output logic                       handshake_arr_1_ready,
  input  logic [WIDTH-1:0]           handshake_arr_1_data,
  input  logic                       handshake_arr_2_valid,
  output logic                       handshake_arr_2_ready,
  input  logic [WIDTH-1:0]           handshake_arr_2_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [1:0]                 out_lane,
  output logic                       out_orr,
  output logic                       out_andr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [2:0]                 proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [2:0]       laneValid;
  logic [WIDTH-1:0] laneData [3];
  logic [2:0]       laneReady;

  logic [1:0]       lastGrant_q, lastGrant_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       stall_q, stall_d;
  logic [2:0]       protoErr_q, protoErr_d;
  logic [WIDTH-1:0] prevData_q [3];
  logic [WIDTH+1:0] mem_q [DEPTH];

  logic             full, enq, deq, grantHit;
  logic [1:0]       grantLane, cand;
  logic [WIDTH+1:0] head;

  assign laneValid   = {handshake_arr_2_valid, handshake_arr_1_valid, handshake_arr_0_valid};
  assign laneData[0] = handshake_arr_0_data;
  assign laneData[1] = handshake_arr_1_data;
  assign laneData[2] = handshake_arr_2_data;
  assign full        = (count_q == CW'(DEPTH));

  // Round-robin search begins one past the last lane that actually enqueued.
  always_comb begin
    grantHit  = 1'b0;
    grantLane = 2'd0;
    cand      = lastGrant_q;
    laneReady = 3'b000;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!grantHit && !full && laneValid[cand]) begin
        grantHit  = 1'b1;
        grantLane = cand;
      end
    end
    if (grantHit) laneReady = 3'b001 << grantLane;
  end

  assign handshake_arr_0_ready = laneReady[0];
  assign handshake_arr_1_ready = laneReady[1];
  assign handshake_arr_2_ready = laneReady[2];

  assign enq = grantHit;
  assign deq = out_valid & out_ready;

  always_comb begin
    lastGrant_d = lastGrant_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    if (enq) begin
      lastGrant_d = grantLane;
      wrPtr_d     = wrPtr_q + AW'(1);
    end
    if (deq) rdPtr_d = rdPtr_q + AW'(1);
    if (enq && !deq)      count_d = count_q + CW'(1);
    else if (!enq && deq) count_d = count_q - CW'(1);
  end

  // A beat left waiting last cycle must be re-offered unchanged this cycle.
  always_comb begin
    stall_d    = 3'b000;
    protoErr_d = protoErr_q;
    for (int i = 0; i < 3; i++) begin
      stall_d[i]    = laneValid[i] & ~laneReady[i];
      protoErr_d[i] = protoErr_q[i] |
                      (stall_q[i] & (~laneValid[i] | (laneData[i] != prevData_q[i])));
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      lastGrant_q <= 2'd2;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      stall_q     <= 3'b000;
      protoErr_q  <= 3'b000;
      for (int i = 0; i < 3; i++) prevData_q[i] <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      protoErr_q  <= protoErr_d;
      for (int i = 0; i < 3; i++) prevData_q[i] <= laneData[i];
    end
  end

  // Storage needs no reset: an empty FIFO's head is don't-care.
  always_ff @(posedge CLK) begin
    if (enq) mem_q[wrPtr_q] <= {grantLane, laneData[grantLane]};
  end

  assign head      = mem_q[rdPtr_q];
  assign out_valid = (count_q != '0);
  assign out_lane  = head[WIDTH+1:WIDTH];
  assign out_data  = head[WIDTH-1:0];
  assign out_orr   = |out_data;
  assign out_andr  = &out_data;
  assign count     = count_q;
  assign proto_err = protoErr_q;

endmodule

// File: tb/tb_bar_foo_handshake_rx.sv
// Directed-vector bench: stimulus pushes hand-computed beats into a scoreboard
// queue that a negedge monitor drains whenever the DUT hands off its FIFO head.
module tb_bar_foo_handshake_rx;
  logic       CLK = 1'b0;
  logic       ASYNCRESET;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic [3:0] d0, d1, d2;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [1:0] out_lane;
  logic       out_orr, out_andr;
  logic [2:0] count;
  logic [2:0] proto_err;

  typedef struct packed {
    logic [1:0] lane;
    logic [3:0] data;
  } exp_t;

  exp_t expQ[$];
  exp_t popped;
  int   compared   = 0;
  int   mismatched = 0;

  logic [2:0] valTab [6];
  logic [2:0] rdyTab [6];
  logic [3:0] simData [10];

  bar_foo_handshake_rx #(.WIDTH(4), .DEPTH(4)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET),
    .handshake_arr_0_valid(v0), .handshake_arr_0_ready(r0), .handshake_arr_0_data(d0),
    .handshake_arr_1_valid(v1), .handshake_arr_1_ready(r1), .handshake_arr_1_data(d1),
    .handshake_arr_2_valid(v2), .handshake_arr_2_ready(r2), .handshake_arr_2_data(d2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_orr(out_orr), .out_andr(out_andr), .count(count), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [3:0] a0, input logic [3:0] a1,
                               input logic [3:0] a2, input logic ordy);
    {v2, v1, v0} = v;
    d0 = a0;
    d1 = a1;
    d2 = a2;
    out_ready = ordy;
    #1;
  endtask

  task automatic pushExp(input logic [1:0] lane, input logic [3:0] data);
    exp_t e;
    e.lane = lane;
    e.data = data;
    expQ.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
    while ((expQ.size() != 0 || count != 3'd0) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("drainDone", {29'd0, count}, 32'd0);
    checkOutput("drainQueue", expQ.size(), 32'd0);
    expQ.delete();
  endtask

  // Scoreboard monitor: every handoff must match the oldest expected beat.
  initial begin
    forever begin
      @(negedge CLK);
      if (!ASYNCRESET && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedPop: got lane=%0d data=%h, required no output", out_lane, out_data);
        end else begin
          popped = expQ.pop_front();
          checkOutput("popLane", {30'd0, out_lane}, {30'd0, popped.lane});
          checkOutput("popData", {28'd0, out_data}, {28'd0, popped.data});
          checkOutput("popOrr", {31'd0, out_orr}, {31'd0, |popped.data});
          checkOutput("popAndr", {31'd0, out_andr}, {31'd0, &popped.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    valTab  = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b100};
    rdyTab  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    simData = '{4'hF, 4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};

    ASYNCRESET = 1'b1;
    {v2, v1, v0} = 3'b000;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 ASYNCRESET = 1'b0;

    // Reset state and combinational ready
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("rstCount", {29'd0, count}, 32'd0);
    checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstErr", {29'd0, proto_err}, 32'd0);
    checkOutput("rstReadyIdle", {29'd0, r2, r1, r0}, 32'd0);
    applyStimulus(3'b001, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("rstReadyL0", {29'd0, r2, r1, r0}, 32'b001);
    applyStimulus(3'b110, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("rstReadyL1", {29'd0, r2, r1, r0}, 32'b010);
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);

    // Lane fairness: grants rotate 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      tick();
      applyStimulus(valTab[k], 4'h1, 4'h2, 4'h3, 1'b1);
      checkOutput("fairReady", {29'd0, r2, r1, r0}, {29'd0, rdyTab[k]});
      checkOutput("fairCountLe1", {31'd0, (count <= 3'd1)}, 32'd1);
      pushExp(2'(k % 3), 4'((k % 3) + 1));
    end
    tick();
    drain();
    checkOutput("fairErr", {29'd0, proto_err}, 32'd0);

    // Fill to full, one dequeue, then the held beat enters
    for (int c = 0; c < 5; c++) begin
      tick();
      applyStimulus(3'b001, 4'(c + 1), 4'h0, 4'h0, 1'b0);
      checkOutput("fillReady0", {31'd0, r0}, (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) pushExp(2'd0, 4'(c + 1));
    end
    checkOutput("fillCountFull", {29'd0, count}, 32'd4);
    tick();
    applyStimulus(3'b001, 4'h5, 4'h0, 4'h0, 1'b1);
    checkOutput("fullNoPass", {31'd0, r0}, 32'd0);
    checkOutput("fullHead", {28'd0, out_data}, 32'h1);
    tick();
    applyStimulus(3'b001, 4'h5, 4'h0, 4'h0, 1'b0);
    checkOutput("afterDeqCount", {29'd0, count}, 32'd3);
    checkOutput("afterDeqReady0", {31'd0, r0}, 32'd1);
    pushExp(2'd0, 4'h5);
    tick();
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("refillCount", {29'd0, count}, 32'd4);
    drain();

    // Simultaneous enqueue/dequeue at count 2 across pointer wrap, incl. reductions
    for (int k = 0; k < 2; k++) begin
      tick();
      applyStimulus(3'b010, 4'h0, simData[k], 4'h0, 1'b0);
      pushExp(2'd1, simData[k]);
    end
    for (int k = 2; k < 10; k++) begin
      tick();
      applyStimulus(3'b010, 4'h0, simData[k], 4'h0, 1'b1);
      checkOutput("simCount", {29'd0, count}, 32'd2);
      checkOutput("simReady1", {31'd0, r1}, 32'd1);
      pushExp(2'd1, simData[k]);
    end
    tick();
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
    checkOutput("simCountEnd", {29'd0, count}, 32'd2);
    drain();

    // Protocol violations while stalled behind a full FIFO
    for (int c = 0; c < 4; c++) begin
      tick();
      applyStimulus(3'b001, 4'(c + 1), 4'h0, 4'h0, 1'b0);
      pushExp(2'd0, 4'(c + 1));
    end
    tick();
    applyStimulus(3'b110, 4'h0, 4'h3, 4'h9, 1'b0);
    checkOutput("protoStallReady", {29'd0, r2, r1, r0}, 32'd0);
    checkOutput("protoFullCount", {29'd0, count}, 32'd4);
    tick();
    applyStimulus(3'b110, 4'h0, 4'h7, 4'h9, 1'b0);
    checkOutput("protoErrNone", {29'd0, proto_err}, 32'b000);
    tick();
    applyStimulus(3'b010, 4'h0, 4'h7, 4'h9, 1'b0);
    checkOutput("protoErrL1", {29'd0, proto_err}, 32'b010);
    tick();
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("protoErrL1L2", {29'd0, proto_err}, 32'b110);
    tick();
    drain();
    checkOutput("protoErrSticky", {29'd0, proto_err}, 32'b110);

    // Asynchronous reset between edges with three beats queued
    for (int c = 0; c < 3; c++) begin
      tick();
      applyStimulus(3'b001, 4'(c + 1), 4'h0, 4'h0, 1'b0);
    end
    tick();
    applyStimulus(3'b000, 4'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("preRstCount", {29'd0, count}, 32'd3);
    #1 ASYNCRESET = 1'b1;
    #1;
    checkOutput("asyncCount", {29'd0, count}, 32'd0);
    checkOutput("asyncValid", {31'd0, out_valid}, 32'd0);
    checkOutput("asyncErr", {29'd0, proto_err}, 32'd0);
    tick();
    ASYNCRESET = 1'b0;
    applyStimulus(3'b111, 4'h1, 4'h2, 4'h3, 1'b1);
    checkOutput("postRstGrant", {29'd0, r2, r1, r0}, 32'b001);
    pushExp(2'd0, 4'h1);
    tick();
    applyStimulus(3'b110, 4'h1, 4'h2, 4'h3, 1'b1);
    checkOutput("postRstGrant1", {29'd0, r2, r1, r0}, 32'b010);
    pushExp(2'd1, 4'h2);
    tick();
    applyStimulus(3'b100, 4'h1, 4'h2, 4'h3, 1'b1);
    checkOutput("postRstGrant2", {29'd0, r2, r1, r0}, 32'b100);
    pushExp(2'd2, 4'h3);
    tick();
    drain();
    checkOutput("postRstErr", {29'd0, proto_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
